// File: rtl/i2s_rx_deserializer_pkg.sv
// Shared definitions for the I2S / left-justified ADC receive path:
// default word size, framing-format codes and the receiver FSM encoding.
package i2s_rx_deserializer_pkg;

    localparam int SAMPLE_WIDTH_DEF = 24;
    localparam int SYNC_STAGES_DEF  = 2;

    // Framing format codes for the I2S_MODE parameter
    localparam bit FMT_I2S = 1'b1;
    localparam bit FMT_LJ  = 1'b0;

    // Slot receiver states
    typedef enum logic [1:0] {
        ST_WAIT_SYNC = 2'd0,
        ST_SKIP      = 2'd1,
        ST_SHIFT     = 2'd2,
        ST_PAD       = 2'd3
    } state_t;

endpackage

// File: rtl/i2s_rx_deserializer_if.sv
// Pin-side serial inputs and sample-side parallel outputs of the receiver.
// o_valid is a one-cycle qualifier with no ready: the consumer must take
// o_left/o_right in that cycle; o_frame_err is an independent one-cycle event.
interface i2s_rx_deserializer_if
    import i2s_rx_deserializer_pkg::*;
#(
    parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF
);

    logic                    i_bck;
    logic                    i_lrck;
    logic                    i_adata;
    logic [SAMPLE_WIDTH-1:0] o_left;
    logic [SAMPLE_WIDTH-1:0] o_right;
    logic                    o_valid;
    logic                    o_frame_err;

    modport master (
        output i_bck,
        output i_lrck,
        output i_adata,
        input  o_left,
        input  o_right,
        input  o_valid,
        input  o_frame_err
    );

    modport slave (
        input  i_bck,
        input  i_lrck,
        input  i_adata,
        output o_left,
        output o_right,
        output o_valid,
        output o_frame_err
    );

endinterface

// File: rtl/i2s_rx_deserializer_sync_edge_det.sv
// N-stage synchronizer for one asynchronous input, with an optional
// rising-edge strobe taken from the synchronized value.
module sync_edge_det #(
    parameter int STAGES   = 2,
    parameter bit EDGE_DET = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_sync[STAGES-1];

    if (EDGE_DET) begin : g_edge
        logic r_prev;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_prev <= 1'b0;
            end else begin
                r_prev <= o_sync;
            end
        end

        assign o_rise = o_sync & ~r_prev;
    end else begin : g_no_edge
        assign o_rise = 1'b0;
    end

endmodule

// File: rtl/i2s_rx_deserializer.sv
// Deserializes the ADC serial stream (BCK/LRCK/ADATA) into left/right sample
// words in the clk domain, publishing a pair only when both slots completed.
module i2s_rx_deserializer
    import i2s_rx_deserializer_pkg::*;
#(
    parameter int SAMPLE_WIDTH    = SAMPLE_WIDTH_DEF,
    parameter bit I2S_MODE        = FMT_I2S,
    parameter bit LEFT_LRCK_LEVEL = 1'b0,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    i2s_rx_deserializer_if.slave  i2s,
    output state_t                o_dbg_state
);

    localparam int CNT_W = $clog2(SAMPLE_WIDTH + 1);

    // All three inputs see the same synchronizer depth so bit/word alignment
    // relative to BCK is preserved.
    logic w_bck_sync_unused;
    logic w_bck_rise;
    logic w_lrck;
    logic w_lrck_rise_unused;
    logic w_adata;
    logic w_adata_rise_unused;

    sync_edge_det #(.STAGES(SYNC_STAGES), .EDGE_DET(1'b1)) u_sync_bck (
        .clk     (clk),
        .rst     (rst),
        .i_async (i2s.i_bck),
        .o_sync  (w_bck_sync_unused),
        .o_rise  (w_bck_rise)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES), .EDGE_DET(1'b0)) u_sync_lrck (
        .clk     (clk),
        .rst     (rst),
        .i_async (i2s.i_lrck),
        .o_sync  (w_lrck),
        .o_rise  (w_lrck_rise_unused)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES), .EDGE_DET(1'b0)) u_sync_adata (
        .clk     (clk),
        .rst     (rst),
        .i_async (i2s.i_adata),
        .o_sync  (w_adata),
        .o_rise  (w_adata_rise_unused)
    );

    state_t                  r_state;
    state_t                  w_state_nx;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_nx;
    logic [CNT_W-1:0]        w_cnt_inc;
    logic [SAMPLE_WIDTH-2:0] r_shift;
    logic [SAMPLE_WIDTH-2:0] w_shift_nx;
    logic [SAMPLE_WIDTH-1:0] w_word;
    logic [SAMPLE_WIDTH-1:0] r_hold_l;
    logic [SAMPLE_WIDTH-1:0] w_hold_l_nx;
    logic [SAMPLE_WIDTH-1:0] r_hold_r;
    logic [SAMPLE_WIDTH-1:0] w_hold_r_nx;
    logic                    r_left_cap;
    logic                    w_left_cap_nx;
    logic                    r_chan_left;
    logic                    w_chan_left_nx;
    logic                    r_done;
    logic                    w_done_nx;
    logic                    w_err_nx;
    logic                    r_lrck_q;
    logic                    r_lrck_seen;
    logic                    w_lrck_edge;
    logic                    w_is_left;
    logic [SAMPLE_WIDTH-1:0] r_left;
    logic [SAMPLE_WIDTH-1:0] r_right;
    logic                    r_valid;
    logic                    r_frame_err;

    // The first bit strobe after reset only primes r_lrck_q; no edge yet.
    assign w_lrck_edge = w_bck_rise & r_lrck_seen & (w_lrck != r_lrck_q);
    assign w_is_left   = (w_lrck == LEFT_LRCK_LEVEL);
    assign w_cnt_inc   = r_cnt + CNT_W'(1);
    assign w_word      = {r_shift, w_adata};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_WAIT_SYNC;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_cnt_nx       = r_cnt;
        w_shift_nx     = r_shift;
        w_hold_l_nx    = r_hold_l;
        w_hold_r_nx    = r_hold_r;
        w_left_cap_nx  = r_left_cap;
        w_chan_left_nx = r_chan_left;
        w_done_nx      = 1'b0;
        w_err_nx       = 1'b0;

        if (w_bck_rise) begin
            if (w_lrck_edge) begin
                // An edge mid-word is a short slot: drop the pair in progress.
                if (r_state == ST_SHIFT) begin
                    w_err_nx      = 1'b1;
                    w_left_cap_nx = 1'b0;
                end
                w_chan_left_nx = w_is_left;
                if (I2S_MODE == FMT_I2S) begin
                    w_state_nx = ST_SKIP;
                    w_cnt_nx   = '0;
                end else begin
                    w_state_nx = ST_SHIFT;
                    w_cnt_nx   = CNT_W'(1);
                    w_shift_nx = {{(SAMPLE_WIDTH-2){1'b0}}, w_adata};
                end
            end else begin
                unique case (r_state)
                    // SKIP: the edge bit was already discarded, this one is the MSB.
                    ST_SKIP, ST_SHIFT: begin
                        w_shift_nx = w_word[SAMPLE_WIDTH-2:0];
                        w_cnt_nx   = w_cnt_inc;
                        w_state_nx = ST_SHIFT;
                        if (w_cnt_inc == CNT_W'(SAMPLE_WIDTH)) begin
                            w_state_nx = ST_PAD;
                            if (r_chan_left) begin
                                w_hold_l_nx   = w_word;
                                w_left_cap_nx = 1'b1;
                            end else begin
                                w_hold_r_nx = w_word;
                                if (r_left_cap) begin
                                    w_done_nx     = 1'b1;
                                    w_left_cap_nx = 1'b0;
                                end
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_shift     <= '0;
            r_hold_l    <= '0;
            r_hold_r    <= '0;
            r_left_cap  <= 1'b0;
            r_chan_left <= 1'b0;
            r_done      <= 1'b0;
            r_lrck_q    <= 1'b0;
            r_lrck_seen <= 1'b0;
            r_left      <= '0;
            r_right     <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nx;
            r_shift     <= w_shift_nx;
            r_hold_l    <= w_hold_l_nx;
            r_hold_r    <= w_hold_r_nx;
            r_left_cap  <= w_left_cap_nx;
            r_chan_left <= w_chan_left_nx;
            r_done      <= w_done_nx;
            r_frame_err <= w_err_nx;
            r_valid     <= r_done;
            if (w_bck_rise) begin
                r_lrck_q    <= w_lrck;
                r_lrck_seen <= 1'b1;
            end
            if (r_done) begin
                r_left  <= r_hold_l;
                r_right <= r_hold_r;
            end
        end
    end

    assign i2s.o_left      = r_left;
    assign i2s.o_right     = r_right;
    assign i2s.o_valid     = r_valid;
    assign i2s.o_frame_err = r_frame_err;
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Directed bench: an I2S-mode and a left-justified receiver share BCK/LRCK,
// each fed its own correctly framed ADATA from hand-chosen sample words.
module tb_i2s_rx_deserializer;
    import i2s_rx_deserializer_pkg::*;

    localparam int SW       = 24;
    localparam int BCK_HALF = 8;
    localparam int SLOT_BCK = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bck = 1'b0;
    logic lrck = 1'b1;
    logic adata_a = 1'b0;
    logic adata_b = 1'b0;

    always #10 clk = ~clk;

    i2s_rx_deserializer_if #(.SAMPLE_WIDTH(SW)) bus_a ();
    i2s_rx_deserializer_if #(.SAMPLE_WIDTH(SW)) bus_b ();

    assign bus_a.i_bck   = bck;
    assign bus_a.i_lrck  = lrck;
    assign bus_a.i_adata = adata_a;
    assign bus_b.i_bck   = bck;
    assign bus_b.i_lrck  = lrck;
    assign bus_b.i_adata = adata_b;

    state_t dbg_a;
    state_t dbg_b;

    i2s_rx_deserializer #(
        .SAMPLE_WIDTH(SW), .I2S_MODE(FMT_I2S), .LEFT_LRCK_LEVEL(1'b0), .SYNC_STAGES(2)
    ) dut_a (
        .clk(clk), .rst(rst), .i2s(bus_a), .o_dbg_state(dbg_a)
    );

    i2s_rx_deserializer #(
        .SAMPLE_WIDTH(SW), .I2S_MODE(FMT_LJ), .LEFT_LRCK_LEVEL(1'b0), .SYNC_STAGES(2)
    ) dut_b (
        .clk(clk), .rst(rst), .i2s(bus_b), .o_dbg_state(dbg_b)
    );

    int n_checks = 0;
    int n_fails  = 0;

    int cyc = 0;
    int vcnt_a = 0, vcnt_b = 0, ecnt_a = 0, ecnt_b = 0;
    int vcyc_a = 0, vcyc_a_prev = 0, vcyc_b = 0;
    logic [SW-1:0] last_l_a = '0, last_r_a = '0, last_l_b = '0, last_r_b = '0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus_a.o_valid === 1'b1) begin
            vcnt_a++;
            last_l_a = bus_a.o_left;
            last_r_a = bus_a.o_right;
            vcyc_a_prev = vcyc_a;
            vcyc_a = cyc;
        end
        if (bus_a.o_frame_err === 1'b1) ecnt_a++;
        if (bus_b.o_valid === 1'b1) begin
            vcnt_b++;
            last_l_b = bus_b.o_left;
            last_r_b = bus_b.o_right;
            vcyc_b = cyc;
        end
        if (bus_b.o_frame_err === 1'b1) ecnt_b++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // I2S: MSB on the BCK after the LRCK change; LJ: MSB on the first BCK.
    function automatic logic bit_i2s(input logic [SW-1:0] w, input int k);
        return (k >= 1 && k <= SW) ? w[SW-k] : 1'b0;
    endfunction

    function automatic logic bit_lj(input logic [SW-1:0] w, input int k);
        return (k < SW) ? w[SW-1-k] : 1'b0;
    endfunction

    task automatic send_bck(input logic lvl, input logic ba, input logic bb);
        bck = 1'b0;
        lrck = lvl;
        adata_a = ba;
        adata_b = bb;
        repeat (BCK_HALF) @(negedge clk);
        bck = 1'b1;
        repeat (BCK_HALF) @(negedge clk);
    endtask

    task automatic send_slot(input logic [SW-1:0] w, input logic lvl, input int from_k, input int to_k);
        for (int k = from_k; k < to_k; k++) send_bck(lvl, bit_i2s(w, k), bit_lj(w, k));
    endtask

    task automatic send_frame(input logic [SW-1:0] l, input logic [SW-1:0] r);
        send_slot(l, 1'b0, 0, SLOT_BCK);
        send_slot(r, 1'b1, 0, SLOT_BCK);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    int v0, vb0, e0, eb0;

    initial begin
        repeat (5) @(negedge clk);
        check("reset_left",  32'(bus_a.o_left), 32'h0);
        check("reset_right", 32'(bus_a.o_right), 32'h0);
        check("reset_valid", 32'(bus_a.o_valid), 32'h0);
        check("reset_err",   32'(bus_a.o_frame_err), 32'h0);
        check("reset_state", 32'(dbg_a), 32'(ST_WAIT_SYNC));
        rst = 1'b0;

        // Basic I2S stream, three identical frames
        send_slot(24'h0, 1'b1, 0, 8);
        v0 = vcnt_a; vb0 = vcnt_b; e0 = ecnt_a;
        send_frame(24'h123456, 24'hABCDEF);
        send_frame(24'h123456, 24'hABCDEF);
        send_frame(24'h123456, 24'hABCDEF);
        check("basic_vcount",   32'(vcnt_a - v0), 32'd3);
        check("basic_left",     32'(last_l_a), 32'h123456);
        check("basic_right",    32'(last_r_a), 32'hABCDEF);
        check("basic_no_err",   32'(ecnt_a - e0), 32'd0);
        check("basic_spacing",  32'(vcyc_a - vcyc_a_prev), 32'd1024);
        check("lj_vcount",      32'(vcnt_b - vb0), 32'd3);
        check("lj_left",        32'(last_l_b), 32'h123456);
        check("lj_right",       32'(last_r_b), 32'hABCDEF);
        check("lj_one_bck_early", 32'(vcyc_a - vcyc_b), 32'd16);

        // Reset held for a few clocks in the middle of a right slot
        send_slot(24'h111111, 1'b0, 0, SLOT_BCK);
        send_slot(24'h222222, 1'b1, 0, 10);
        check("midright_state", 32'(dbg_a), 32'(ST_SHIFT));
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("midright_rst_left",  32'(bus_a.o_left), 32'h0);
        check("midright_rst_right", 32'(bus_a.o_right), 32'h0);
        check("midright_rst_state", 32'(dbg_a), 32'(ST_WAIT_SYNC));
        rst = 1'b0;
        v0 = vcnt_a;
        send_slot(24'h222222, 1'b1, 10, SLOT_BCK);
        check("midright_no_valid", 32'(vcnt_a - v0), 32'd0);
        send_frame(24'h5A5A5A, 24'hC3C3C3);
        check("midright_vcount", 32'(vcnt_a - v0), 32'd1);
        check("midright_left",   32'(last_l_a), 32'h5A5A5A);
        check("midright_right",  32'(last_r_a), 32'hC3C3C3);

        // Short left slot: LRCK toggles after 16 data bits
        send_frame(24'h123456, 24'hABCDEF);
        v0 = vcnt_a; e0 = ecnt_a; eb0 = ecnt_b;
        send_slot(24'h555555, 1'b0, 0, 17);
        send_slot(24'h0F0F0F, 1'b1, 0, SLOT_BCK);
        check("short_err_once",  32'(ecnt_a - e0), 32'd1);
        check("short_no_valid",  32'(vcnt_a - v0), 32'd0);
        check("short_hold_left", 32'(bus_a.o_left), 32'h123456);
        check("short_hold_right", 32'(bus_a.o_right), 32'hABCDEF);
        check("lj_short_err",    32'(ecnt_b - eb0), 32'd1);

        // Back-to-back frames with sign-boundary words
        v0 = vcnt_a; e0 = ecnt_a; vb0 = vcnt_b;
        send_frame(24'h800000, 24'h7FFFFF);
        check("b2b1_vcount", 32'(vcnt_a - v0), 32'd1);
        check("b2b1_left",   32'(last_l_a), 32'h800000);
        check("b2b1_right",  32'(last_r_a), 32'h7FFFFF);
        send_frame(24'h000001, 24'hFFFFFF);
        check("b2b2_vcount",  32'(vcnt_a - v0), 32'd2);
        check("b2b2_left",    32'(last_l_a), 32'h000001);
        check("b2b2_right",   32'(last_r_a), 32'hFFFFFF);
        check("b2b_spacing",  32'(vcyc_a - vcyc_a_prev), 32'd1024);
        check("b2b_no_err",   32'(ecnt_a - e0), 32'd0);
        check("lj_b2b_vcount", 32'(vcnt_b - vb0), 32'd2);
        check("lj_b2b_right", 32'(last_r_b), 32'hFFFFFF);

        // Single-clock reset pulse in the middle of a left word
        send_slot(24'h333333, 1'b0, 0, 10);
        check("pulse_pre_state", 32'(dbg_a), 32'(ST_SHIFT));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("pulse_left",  32'(bus_a.o_left), 32'h0);
        check("pulse_right", 32'(bus_a.o_right), 32'h0);
        check("pulse_valid", 32'(bus_a.o_valid), 32'h0);
        check("pulse_err",   32'(bus_a.o_frame_err), 32'h0);
        check("pulse_state", 32'(dbg_a), 32'(ST_WAIT_SYNC));
        v0 = vcnt_a;
        send_slot(24'h333333, 1'b0, 10, SLOT_BCK);
        send_slot(24'h444444, 1'b1, 0, SLOT_BCK);
        check("pulse_no_stale", 32'(vcnt_a - v0), 32'd0);
        send_frame(24'h0A0B0C, 24'h0D0E0F);
        check("pulse_vcount", 32'(vcnt_a - v0), 32'd1);
        check("pulse_left_after",  32'(last_l_a), 32'h0A0B0C);
        check("pulse_right_after", 32'(last_r_a), 32'h0D0E0F);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
